// File: rtl/rca_ctrl_defs.sv
// Shared definitions for the sequential ripple-carry add/subtract controller:
// slice width, FSM state encoding and a helper for the number of passes.
package rca_ctrl_defs;

    // Width of the shared combinational adder slice.
    localparam int SLICE_W = 4;

    // Controller states; the encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of adder passes needed for an operand of the given width.
    function automatic int slice_count(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/four_bit_RCA.sv
// Purely combinational 4-bit ripple-carry adder slice, shared by the
// sequencer across all passes of a wide add/subtract.
module four_bit_RCA
    import rca_ctrl_defs::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               Cin,
    output logic [SLICE_W-1:0] S,
    output logic               Cout
);

    logic [SLICE_W:0] w_c;

    // Ripple the carry through one full adder per bit.
    always_comb begin
        w_c[0] = Cin;
        S      = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            S[i]     = A[i] ^ B[i] ^ w_c[i];
            w_c[i+1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
        end
    end

    assign Cout = w_c[SLICE_W];

endmodule

// File: rtl/rca_seq_add_ctrl.sv
// Sequencer that performs a WIDTH-bit add/subtract by running one 4-bit
// ripple-carry slice over WIDTH/4 cycles, chaining the carry through a
// register. Start/done handshake toward the requester; result, unsigned
// carry-out and signed overflow are held from DONE until the next start.
module rca_seq_add_ctrl
    import rca_ctrl_defs::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NSLICE = slice_count(WIDTH);
    localparam int IDX_W  = $clog2(NSLICE + 1);
    localparam int SEL_W  = $clog2(NSLICE);
    localparam int MSB    = WIDTH - 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_beff;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic [SEL_W-1:0]   w_sel;
    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_s;
    logic               w_cout;

    // Pick the operand slice for the current pass; outside RUN the index may
    // sit one past the last slice, so it is forced to slice 0 there.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        w_sel     = '0;
        if (r_state == ST_RUN) begin
            w_sel = r_idx[SEL_W-1:0];
        end
        w_a_slice = r_a[w_sel*SLICE_W +: SLICE_W];
        w_b_slice = r_beff[w_sel*SLICE_W +: SLICE_W];
    end

    four_bit_RCA u_rca (
        .A    (w_a_slice),
        .B    (w_b_slice),
        .Cin  (r_carry),
        .S    (w_s),
        .Cout (w_cout)
    );

    // Controller FSM: accept requests, step the slice index while storing
    // each partial sum and carry, then flag completion for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: operand and result registers are reset too, so a reset
            // mid-operation leaves every output at a known zero.
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_beff  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples the pre-edge values regardless of statement order.
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_idx   <= '0;
                        r_a     <= A;
                        r_beff  <= Sub ? ~B : B;
                        r_carry <= Sub ? 1'b1 : Cin;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sum[w_sel*SLICE_W +: SLICE_W] <= w_s;
                    r_carry <= w_cout;
                    r_idx   <= r_idx + IDX_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_DONE;
                        r_cout  <= w_cout;
                        // Same-sign operands whose sum flips sign overflowed;
                        // w_s holds the sum MSB being written this edge.
                        r_ovf   <= (r_a[MSB] == r_beff[MSB]) &&
                                   (w_s[SLICE_W-1] != r_a[MSB]);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign S    = r_sum;
    assign Cout = r_cout;
    assign Ovf  = r_ovf;

endmodule

// File: tb/tb_rca_seq_add_ctrl.sv
// Self-checking bench for rca_seq_add_ctrl (WIDTH=16). Stimulus pushes the
// expected result into a scoreboard; a monitor pops it whenever done is seen.
module tb_rca_seq_add_ctrl;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
        int               due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             Ovf;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;
    int   n_issued = 0;

    rca_seq_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .Sub   (Sub),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub, input int due);
        exp_t   e;
        longint ua, ub, sa, sbv, c, u, sres, smax, smin;
        ua   = a;
        ub   = b;
        sa   = $signed(a);
        sbv  = $signed(b);
        c    = cin;
        smax = (longint'(1) << (WIDTH - 1)) - 1;
        smin = -(longint'(1) << (WIDTH - 1));
        if (sub) begin
            u      = ua - ub;
            e.cout = (ua >= ub);
            sres   = sa - sbv;
        end else begin
            u      = ua + ub + c;
            e.cout = (u >= (longint'(1) << WIDTH));
            sres   = sa + sbv + c;
        end
        e.s   = u[WIDTH-1:0];
        e.ovf = (sres > smax) || (sres < smin);
        e.due = due;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sum", S, e.s);
                check("cout", Cout, e.cout);
                check("ovf", Ovf, e.ovf);
                check("latency", cyc, e.due);
            end
        end
    end

    // Called at a negedge; returns one negedge later with start dropped.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic sub);
        A     = a;
        B     = b;
        Cin   = cin;
        Sub   = sub;
        start = 1'b1;
        sb.push_back(model(a, b, cin, sub, cyc + 1 + NSLICE));
        n_issued++;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait; returns at the negedge where done is high.
    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * NSLICE; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, seen, 1);
    endtask

    task automatic run_dir(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub,
                           input logic [WIDTH-1:0] exp_s, input logic exp_c, input logic exp_v);
        issue(a, b, cin, sub);
        wait_done("dir_done_seen");
        check("dir_sum", S, exp_s);
        check("dir_cout", Cout, exp_c);
        check("dir_ovf", Ovf, exp_v);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        Cin   = 1'b0;
        Sub   = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_S", S, 0);
        check("rst_cout", Cout, 0);
        check("rst_ovf", Ovf, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: plain add, busy for NSLICE cycles then a single done pulse.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        for (int k = 0; k < NSLICE; k++) begin
            check("t1_busy", busy, 1);
            check("t1_no_done_yet", done, 0);
            @(negedge clk);
        end
        check("t1_done", done, 1);
        check("t1_busy_low", busy, 0);
        check("t1_sum", S, 16'h5555);
        check("t1_cout", Cout, 0);
        check("t1_ovf", Ovf, 0);
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_hold_sum", S, 16'h5555);
        @(negedge clk);

        // 2: unsigned wrap and carry chaining across slices.
        run_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_dir(16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
        // 3: signed overflow both directions.
        run_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_dir(16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        // 4: subtract, Cin ignored.
        run_dir(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_dir(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);

        // 5a: start during RUN is ignored.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        A     = 16'hAAAA;
        B     = 16'h5555;
        Sub   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5a_done_seen");
        check("t5a_sum_first_op", S, 16'h3333);
        repeat (NSLICE + 3) @(negedge clk);
        check("t5a_one_done", n_done, n_issued);

        // 5b: start held in the DONE cycle launches the next RUN with no gap.
        issue(16'h0100, 16'h0200, 1'b0, 1'b0);
        wait_done("t5b_first_done");
        issue(16'h0F0F, 16'h0101, 1'b0, 1'b1);
        check("t5b_busy_no_gap", busy, 1);
        wait_done("t5b_second_done");
        check("t5b_sum", S, 16'h0E0E);
        @(negedge clk);

        // 6: reset in RUN cycle 2 aborts with no done, then a fresh op works.
        issue(16'h1357, 16'h2468, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        n_issued--;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_S", S, 0);
        check("t6_cout", Cout, 0);
        check("t6_ovf", Ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NSLICE + 1; k++) begin
            check("t6_no_done_after_abort", done, 0);
            @(negedge clk);
        end
        run_dir(16'h1357, 16'h2468, 1'b0, 1'b0, 16'h37BF, 1'b0, 1'b0);

        // Random operations with random idle gaps (zero gap = back-to-back).
        for (int n = 0; n < 40; n++) begin
            issue(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
            wait_done("rand_done_seen");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (NSLICE + 3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("done_count", n_done, n_issued);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
